// File: rtl/fc_argmax_if.sv
// fc_argmax_if: score stream in, argmax result out, one bundle.
// slave = argmax block side, master = producer/consumer side.
interface fc_argmax_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] S_AXIS_TDATA;
  logic                  S_AXIS_TVALID;
  logic                  S_AXIS_TLAST;
  logic                  S_AXIS_TREADY;
  logic [DATA_WIDTH-1:0] M_AXIS_TDATA;
  logic [DATA_WIDTH-1:0] M_AXIS_TUSER;
  logic                  M_AXIS_TERR;
  logic                  M_AXIS_TVALID;
  logic                  M_AXIS_TLAST;
  logic                  M_AXIS_TREADY;

  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST,
    output S_AXIS_TREADY,
    output M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TERR,
    output M_AXIS_TVALID, M_AXIS_TLAST,
    input  M_AXIS_TREADY
  );

  modport master (
    output S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST,
    input  S_AXIS_TREADY,
    input  M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TERR,
    input  M_AXIS_TVALID, M_AXIS_TLAST,
    output M_AXIS_TREADY
  );
endinterface

// File: rtl/fc_argmax.sv
// fc_argmax: streaming argmax over OUTPUT_SIZE signed scores.
// Ports: clk, rst (async high), bus (fc_argmax_if.slave).
module fc_argmax #(
  parameter int DATA_WIDTH  = 32,
  parameter int OUTPUT_SIZE = 10,
  parameter int IDX_WIDTH   = 4
) (
  input logic         clk,
  input logic         rst,
  fc_argmax_if.slave  bus
);
  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_K =
    IDX_WIDTH'(OUTPUT_SIZE - 1);

  state_t                state_q, state_d;
  logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] best_q, best_d;
  logic                  err_q, err_d;
  // Registered ready keeps the input closed during reset
  // and for the whole OUT state.
  logic                  rdy_q, rdy_d;

  logic acc_beat;
  logic last_k;
  logic better;

  assign acc_beat = bus.S_AXIS_TVALID & rdy_q;
  assign last_k   = (cnt_q == LAST_K);
  assign better   = $signed(bus.S_AXIS_TDATA) > $signed(best_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    best_d  = best_q;
    err_d   = err_q;
    unique case (state_q)
      ACC: begin
        if (acc_beat) begin
          if (cnt_q == '0 || better) begin
            best_d = bus.S_AXIS_TDATA;
            idx_d  = cnt_q;
          end
          cnt_d = cnt_q + 1'b1;
          if (bus.S_AXIS_TLAST) begin
            state_d = OUT;
            err_d   = ~last_k;
          end else if (last_k) begin
            state_d = DRAIN;
            err_d   = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (acc_beat && bus.S_AXIS_TLAST) state_d = OUT;
      end
      OUT: begin
        if (bus.M_AXIS_TREADY) begin
          state_d = ACC;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
    rdy_d = (state_d != OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      cnt_q   <= '0;
      idx_q   <= '0;
      best_q  <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      best_q  <= best_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.S_AXIS_TREADY = rdy_q;
  assign bus.M_AXIS_TVALID = (state_q == OUT);
  assign bus.M_AXIS_TLAST  = (state_q == OUT);
  assign bus.M_AXIS_TDATA  =
    {{(DATA_WIDTH-IDX_WIDTH){1'b0}}, idx_q};
  assign bus.M_AXIS_TUSER  = best_q;
  assign bus.M_AXIS_TERR   = err_q;
endmodule

// File: tb/tb_fc_argmax.sv
// tb_fc_argmax: directed vector table plus stall/reset
// sequences for fc_argmax.
module tb_fc_argmax;
  logic clk;
  logic rst;

  fc_argmax_if #(.DATA_WIDTH(32)) bus ();

  fc_argmax #(
    .DATA_WIDTH (32),
    .OUTPUT_SIZE(10),
    .IDX_WIDTH  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] sc [12];
    int                 n;
    logic [31:0]        eidx;
    logic signed [31:0] eval;
    logic               eerr;
  } vec_t;

  vec_t vt [6];
  int   total;
  int   passed;
  int   acc;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic send(input int v, input int nb, input bit tl);
    int w;
    acc = 0;
    for (int i = 0; i < nb; i++) begin
      bus.S_AXIS_TDATA  = vt[v].sc[i];
      bus.S_AXIS_TVALID = 1'b1;
      bus.S_AXIS_TLAST  = tl && (i == nb - 1);
      w = 0;
      while (!bus.S_AXIS_TREADY && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (w >= 50) begin
        total++;
        $display("FAIL tready_timeout: vec %0d beat %0d never accepted",
                 v, i);
        break;
      end
      @(posedge clk); #1;
      acc++;
    end
    bus.S_AXIS_TVALID = 1'b0;
    bus.S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic check_result(input int v);
    check("tvalid", {31'd0, bus.M_AXIS_TVALID}, 32'd1);
    check("tlast",  {31'd0, bus.M_AXIS_TLAST},  32'd1);
    check("tdata",  bus.M_AXIS_TDATA, vt[v].eidx);
    check("tuser",  bus.M_AXIS_TUSER, vt[v].eval);
    check("terr",   {31'd0, bus.M_AXIS_TERR}, {31'd0, vt[v].eerr});
  endtask

  initial begin
    total  = 0;
    passed = 0;
    for (int v = 0; v < 6; v++)
      for (int i = 0; i < 12; i++) vt[v].sc[i] = 0;
    // 0: 3*i
    for (int i = 0; i < 10; i++) vt[0].sc[i] = 3 * i;
    vt[0].n = 10; vt[0].eidx = 9; vt[0].eval = 27; vt[0].eerr = 0;
    // 1: negatives
    vt[1].sc[0] = -5; vt[1].sc[1] = -1; vt[1].sc[2] = -7;
    vt[1].sc[3] = -3; vt[1].sc[4] = -9; vt[1].sc[5] = -2;
    vt[1].sc[6] = -8; vt[1].sc[7] = -4; vt[1].sc[8] = -6;
    vt[1].sc[9] = -10;
    vt[1].n = 10; vt[1].eidx = 1; vt[1].eval = -1; vt[1].eerr = 0;
    // 2: tie at 2 and 6
    vt[2].sc[2] = 100; vt[2].sc[6] = 100;
    vt[2].n = 10; vt[2].eidx = 2; vt[2].eval = 100; vt[2].eerr = 0;
    // 3: short frame
    vt[3].sc[0] = 1; vt[3].sc[1] = 9; vt[3].sc[2] = 4;
    vt[3].sc[3] = 2; vt[3].sc[4] = 3;
    vt[3].n = 5; vt[3].eidx = 1; vt[3].eval = 9; vt[3].eerr = 1;
    // 4: full frame again, err must clear
    vt[4] = vt[0];
    // 5: long frame, extra beats ignored
    for (int i = 0; i < 10; i++) vt[5].sc[i] = i;
    vt[5].sc[10] = 1000; vt[5].sc[11] = 1000;
    vt[5].n = 12; vt[5].eidx = 9; vt[5].eval = 9; vt[5].eerr = 1;

    rst = 1'b1;
    bus.S_AXIS_TDATA  = '0;
    bus.S_AXIS_TVALID = 1'b0;
    bus.S_AXIS_TLAST  = 1'b0;
    bus.M_AXIS_TREADY = 1'b1;
    #12;
    check("rst_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd0);
    check("rst_tvalid", {31'd0, bus.M_AXIS_TVALID}, 32'd0);
    check("rst_tdata",  bus.M_AXIS_TDATA, 32'd0);
    check("rst_tuser",  bus.M_AXIS_TUSER, 32'd0);
    check("rst_terr",   {31'd0, bus.M_AXIS_TERR}, 32'd0);
    #5 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd1);

    for (int v = 0; v < 6; v++) begin
      send(v, vt[v].n, 1'b1);
      check("beats_acc", acc, vt[v].n);
      check_result(v);
      @(posedge clk); #1;
      check("post_hs_tvalid", {31'd0, bus.M_AXIS_TVALID}, 32'd0);
      check("post_hs_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd1);
    end

    // Stall the result for 5 cycles
    bus.M_AXIS_TREADY = 1'b0;
    send(0, 10, 1'b1);
    check_result(0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("stall_tvalid", {31'd0, bus.M_AXIS_TVALID}, 32'd1);
      check("stall_tdata",  bus.M_AXIS_TDATA, 32'd9);
      check("stall_tuser",  bus.M_AXIS_TUSER, 32'd27);
      check("stall_sready", {31'd0, bus.S_AXIS_TREADY}, 32'd0);
    end
    bus.M_AXIS_TREADY = 1'b1;
    @(posedge clk); #1;
    check("unstall_tvalid", {31'd0, bus.M_AXIS_TVALID}, 32'd0);
    check("unstall_sready", {31'd0, bus.S_AXIS_TREADY}, 32'd1);

    // Reset mid-frame after 4 beats
    send(2, 4, 1'b0);
    check("mid_no_valid", {31'd0, bus.M_AXIS_TVALID}, 32'd0);
    rst = 1'b1;
    #2;
    check("mrst_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd0);
    check("mrst_tdata",  bus.M_AXIS_TDATA, 32'd0);
    check("mrst_tuser",  bus.M_AXIS_TUSER, 32'd0);
    check("mrst_terr",   {31'd0, bus.M_AXIS_TERR}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(1, 10, 1'b1);
    check("after_rst_acc", acc, 10);
    check_result(1);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
